// File: rtl/vga_sync_output.sv
// VGA raster timing generator with a delayed sync/colour output stage.
// Latency: counters are registered; hsync/vsync/rgb trail the counters by PIPE_DELAY+1 cycles.
// Backpressure: none; free-running at one pixel per clk_in cycle.
module vga_sync_output #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic [9:0] counter_H,
    output logic [9:0] counter_V,
    input  logic       colour,
    input  logic [5:0] fg_rgb,
    input  logic [5:0] bg_rgb,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counter-domain boundaries, sized to the counter width so compares stay 10-bit.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Raster position
    logic [9:0] counter_h_q, counter_h_d;
    logic [9:0] counter_v_q, counter_v_d;

    // Raw timing decoded from the current counter values
    logic hs_raw;
    logic vs_raw;
    logic de_raw;

    // Delay lines: index 0 is the youngest stage, PIPE_DELAY-1 the oldest
    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] de_pipe_q, de_pipe_d;

    // Output registers
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [5:0] rgb_q, rgb_d;
    logic       frame_tick_q, frame_tick_d;

    // Next raster position: H wraps every line, V advances only on the H wrap
    always_comb begin
        counter_h_d = counter_h_q + 10'd1;
        counter_v_d = counter_v_q;
        if (counter_h_q == H_LAST) begin
            counter_h_d = 10'd0;
            if (counter_v_q == V_LAST) begin
                counter_v_d = 10'd0;
            end else begin
                counter_v_d = counter_v_q + 10'd1;
            end
        end
    end

    // Decode active-low sync pulses and the visible-area flag from the counters
    always_comb begin
        hs_raw = !((counter_h_q >= H_SYNC_FIRST) && (counter_h_q <= H_SYNC_LAST));
        vs_raw = !((counter_v_q >= V_SYNC_FIRST) && (counter_v_q <= V_SYNC_LAST));
        de_raw = (counter_h_q < H_VIS) && (counter_v_q < V_VIS);
    end

    // Shift the raw timing through the delay line so it lines up with the colour input
    always_comb begin
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        de_pipe_d    = de_pipe_q;
        hs_pipe_d[0] = hs_raw;
        vs_pipe_d[0] = vs_raw;
        de_pipe_d[0] = de_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
            de_pipe_d[i] = de_pipe_q[i-1];
        end
    end

    // Output stage: syncs and pixel colour are registered on the same edge; the
    // frame tick is derived from the next counter values so it coincides with (640,480)
    always_comb begin
        hsync_d = hs_pipe_q[PIPE_DELAY-1];
        vsync_d = vs_pipe_q[PIPE_DELAY-1];
        if (de_pipe_q[PIPE_DELAY-1]) begin
            rgb_d = colour ? fg_rgb : bg_rgb;
        end else begin
            rgb_d = 6'b000000;
        end
        frame_tick_d = (counter_h_d == H_VIS) && (counter_v_d == V_VIS);
    end

    // Raster counters
    always_ff @(posedge clk_in) begin
        if (reset) begin
            counter_h_q <= 10'd0;
            counter_v_q <= 10'd0;
        end else begin
            counter_h_q <= counter_h_d;
            counter_v_q <= counter_v_d;
        end
    end

    // Delay line; syncs idle high and display-enable idles low so nothing leaks out after reset
    always_ff @(posedge clk_in) begin
        if (reset) begin
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
            de_pipe_q <= '0;
        end else begin
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            de_pipe_q <= de_pipe_d;
        end
    end

    // Output registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            rgb_q        <= 6'b000000;
            frame_tick_q <= 1'b0;
        end else begin
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign counter_H  = counter_h_q;
    assign counter_V  = counter_v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/vga_sync_output.md
VGA_SYNC_OUTPUT -- requirements
Module: vga_sync_output

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter PIPE_DELAY, default 2, legal range 1..7; cycles from counter value C to colour for C being valid on the colour input.
REQ-010 SHALL have port clk_in, input, 1 bit; 25 MHz pixel clock, the only clock.
REQ-011 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-012 SHALL have port counter_H, output, 10 bits; current horizontal pixel count (registered).
REQ-013 SHALL have port counter_V, output, 10 bits; current line count (registered).
REQ-014 SHALL have port colour, input, 1 bit; pixel value from the picture processing stage, 0 = background, 1 = foreground.
REQ-015 SHALL have port fg_rgb, input, 6 bits; foreground colour {R[1:0],G[1:0],B[1:0]}.
REQ-016 SHALL have port bg_rgb, input, 6 bits; background colour, same format.
REQ-017 SHALL have port hsync, output, 1 bit; horizontal sync, active-low.
REQ-018 SHALL have port vsync, output, 1 bit; vertical sync, active-low.
REQ-019 SHALL have port rgb, output, 6 bits; pixel drive {R[1:0],G[1:0],B[1:0]}.
REQ-020 SHALL have port frame_tick, output, 1 bit; one-cycle pulse at start of vertical blanking.

Function
REQ-021 counter_H SHALL increment by 1 every clk_in edge and wrap from H_TOTAL-1 (H_TOTAL = sum of H params, 800) to 0.
REQ-022 counter_V SHALL increment by 1 only on the edge where counter_H wraps, and wrap from V_TOTAL-1 (525) to 0 on that same edge.
REQ-023 Raw hsync SHALL be 0 while counter_H is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751), else 1.
REQ-024 Raw vsync SHALL be 0 while counter_V is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491), else 1.
REQ-025 Raw display_on SHALL be 1 iff counter_H < H_VISIBLE and counter_V < V_VISIBLE.
REQ-026 Raw hsync, vsync and display_on SHALL pass through a PIPE_DELAY-stage register delay line, followed by one output register.
REQ-027 rgb SHALL be registered at the same edge as the final sync stage: fg_rgb if delayed display_on=1 and colour=1; bg_rgb if delayed display_on=1 and colour=0; 6'b000000 otherwise.
REQ-028 hsync, vsync and rgb at the outputs SHALL all correspond to the same counter value, PIPE_DELAY+1 cycles after counter_H/counter_V held it.
REQ-029 fg_rgb and bg_rgb SHALL be sampled every cycle with no internal latching; a change takes effect on the next rgb update.
REQ-030 frame_tick SHALL be 1 for exactly the one cycle in which counter_H = H_VISIBLE and counter_V = V_VISIBLE (640, 480), 0 otherwise, and SHALL be registered, not combinational from the counters.
REQ-031 colour SHALL be ignored whenever delayed display_on is 0.

Reset
REQ-032 While reset=1 at an edge: counter_H=0, counter_V=0, hsync=1, vsync=1, rgb=0, frame_tick=0; all delay-line sync stages=1; display_on stages=0.
REQ-033 Reset mid-frame SHALL take effect at the next edge; counting restarts at (0,0) on the first edge with reset=0.
REQ-034 After reset release, rgb SHALL remain 0 until a display_on=1 value reaches the end of the delay line.

Verification
REQ-035 Release reset, run 800x525 cycles -> exactly one frame_tick, with counters = (640,480) in that cycle; counters = (0,0) again at cycle 420000.
REQ-036 Count hsync low per line -> 96 consecutive cycles; falling edge PIPE_DELAY+1 cycles after counter_H=656.
REQ-037 Count vsync low per frame -> 2 lines (1600 cycles), beginning PIPE_DELAY+1 cycles after counters = (0,490).
REQ-038 fg_rgb=6'h3F, bg_rgb=6'h05, colour toggling each cycle -> rgb alternates 3F/05 in the visible area, 00 during blanking at every pixel with H>=640 or V>=480.
REQ-039 Assert reset at counters (300,200) for 3 cycles -> outputs at reset values; counter_H=1 one cycle after release.
REQ-040 Repeat REQ-036 with PIPE_DELAY=1 and PIPE_DELAY=7 -> sync-to-counter offset is 2 and 8 cycles respectively.
